// File: rtl/traffic_controller.sv
// Four-way junction phase sequencer: timed greens on an external tick, all-red clearance,
// round-robin lane selection that skips empty lanes, and an emergency all-red override.
module traffic_controller #(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned GREEN_TIME   = 20,
  parameter int unsigned YELLOW_TIME  = 4,
  parameter int unsigned ALL_RED_TIME = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic [3:0]       car_present_i,
  input  logic             emergency_i,
  output logic [3:0]       state_o,
  output logic             almost_done_o,
  output logic [CNT_W-1:0] remaining_o
);

  if (GREEN_TIME < 2 || (GREEN_TIME >> CNT_W) != 0 || YELLOW_TIME < 1 ||
      YELLOW_TIME >= GREEN_TIME || ALL_RED_TIME < 1 || (ALL_RED_TIME >> CNT_W) != 0)
  begin : gen_bad_params
    $error("traffic_controller: parameter out of range");
  end

  localparam logic [CNT_W-1:0] GreenCnt  = CNT_W'(GREEN_TIME);
  localparam logic [CNT_W-1:0] YellowCnt = CNT_W'(YELLOW_TIME);
  localparam logic [CNT_W-1:0] RedCnt    = CNT_W'(ALL_RED_TIME);
  localparam logic [CNT_W-1:0] OneCnt    = CNT_W'(1);

  typedef enum logic [1:0] {StAllRed, StGreen, StEmerg} fsm_e;

  fsm_e             fsm_q;
  logic [3:0]       state_q;
  logic             almost_done_q;
  logic [CNT_W-1:0] remaining_q;
  logic [1:0]       last_lane_q;  // 0 = L1 .. 3 = L4
  logic [1:0]       next_lane;
  logic [CNT_W-1:0] remaining_dec;

  assign remaining_dec = remaining_q - OneCnt;

  // Descending scan so the nearest lane after last_lane_q wins; k=4 wraps to last_lane_q.
  always_comb begin
    next_lane = last_lane_q + 2'd1;
    for (int k = 4; k >= 1; k--) begin
      if (car_present_i[last_lane_q + 2'(k)]) begin
        next_lane = last_lane_q + 2'(k);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm_q         <= StAllRed;
      state_q       <= 4'b0000;
      almost_done_q <= 1'b0;
      remaining_q   <= RedCnt;
      last_lane_q   <= 2'd3;
    end else if (emergency_i) begin
      fsm_q         <= StEmerg;
      state_q       <= 4'b0000;
      almost_done_q <= 1'b0;
      remaining_q   <= '0;
    end else begin
      unique case (fsm_q)
        StEmerg: begin
          fsm_q       <= StAllRed;
          remaining_q <= RedCnt;
        end
        StAllRed: begin
          if (tick_i) begin
            if (remaining_q == OneCnt) begin
              fsm_q         <= StGreen;
              state_q       <= 4'b0001 << next_lane;
              remaining_q   <= GreenCnt;
              almost_done_q <= 1'b0;
              last_lane_q   <= next_lane;
            end else begin
              remaining_q <= remaining_dec;
            end
          end
        end
        StGreen: begin
          if (tick_i) begin
            if (remaining_q == OneCnt) begin
              fsm_q         <= StAllRed;
              state_q       <= 4'b0000;
              remaining_q   <= RedCnt;
              almost_done_q <= 1'b0;
            end else begin
              remaining_q   <= remaining_dec;
              almost_done_q <= (remaining_dec <= YellowCnt);
            end
          end
        end
        default: begin
          fsm_q       <= StAllRed;
          state_q     <= 4'b0000;
          remaining_q <= RedCnt;
        end
      endcase
    end
  end

  assign state_o       = state_q;
  assign almost_done_o = almost_done_q;
  assign remaining_o   = remaining_q;

endmodule
